mem_loader: RTL

//  Host-side initiator for the cpu external memory ports (addr_ext*/wen_ext*/ren_ext*/wdata_ext*/rdata_ext_2).

---
 rtl/mem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Host-side sequencer for the cpu external memory ports: load imem, load dmem,
// run the cpu for a fixed number of cycles, then stream a dmem window back out.
module mem_loader #(
  parameter int          CNT_W     = 16,
  parameter logic [63:0] IMEM_BASE = 64'd0,
  parameter logic [63:0] DMEM_BASE = 64'd0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_instr,
  input  logic [CNT_W-1:0] n_data,
  input  logic [31:0]      run_cycles,
  input  logic [CNT_W-1:0] n_dump,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_I   = 3'd1;
  localparam logic [2:0] S_LOAD_D   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DUMP_RD  = 3'd4;
  localparam logic [2:0] S_DUMP_CAP = 3'd5;
  localparam logic [2:0] S_DUMP_OUT = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] n_instr_q;
  logic [CNT_W-1:0] n_data_q;
  logic [CNT_W-1:0] n_dump_q;
  logic [31:0]      run_cnt;

  logic             imem_vld_p1;
  logic [63:0]      imem_addr_p1;
  logic [31:0]      imem_data_p1;
  logic             dmem_vld_p1;
  logic [63:0]      dmem_addr_p1;
  logic [63:0]      dmem_data_p1;
  logic [63:0]      m_data_q;

  logic             hs;
  logic [63:0]      imem_off;
  logic [63:0]      dmem_off;

  // First phase, in sequence order, that still has work to do.
  function automatic logic [2:0] first_phase(input logic ni_nz, input logic nd_nz,
                                             input logic rc_nz, input logic nm_nz);
    if (ni_nz)      return S_LOAD_I;
    else if (nd_nz) return S_LOAD_D;
    else if (rc_nz) return S_RUN;
    else if (nm_nz) return S_DUMP_RD;
    else            return S_DONE;
  endfunction

  // k counts accepted words, so ready drops the cycle after the last accept.
  assign s_ready  = ((state == S_LOAD_I) && (k != n_instr_q)) ||
                    ((state == S_LOAD_D) && (k != n_data_q));
  assign hs       = s_valid & s_ready;
  assign imem_off = {{(62-CNT_W){1'b0}}, k, 2'b00};
  assign dmem_off = {{(61-CNT_W){1'b0}}, k, 3'b000};

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      n_instr_q    <= '0;
      n_data_q     <= '0;
      n_dump_q     <= '0;
      run_cnt      <= '0;
      imem_vld_p1  <= 1'b0;
      imem_addr_p1 <= '0;
      imem_data_p1 <= '0;
      dmem_vld_p1  <= 1'b0;
      dmem_addr_p1 <= '0;
      dmem_data_p1 <= '0;
      m_data_q     <= '0;
    end else begin
      imem_vld_p1 <= 1'b0;
      dmem_vld_p1 <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_instr_q <= n_instr;
            n_data_q  <= n_data;
            n_dump_q  <= n_dump;
            run_cnt   <= run_cycles;
            k         <= '0;
            state     <= first_phase(n_instr != '0, n_data != '0,
                                     run_cycles != '0, n_dump != '0);
          end
        end
        // ---- stage p1: accepted word becomes a one-cycle imem write ----
        S_LOAD_I: begin
          if (hs) begin
            imem_vld_p1  <= 1'b1;
            imem_addr_p1 <= IMEM_BASE + imem_off;
            imem_data_p1 <= s_data[31:0];
            k            <= k + CNT_ONE;
          end else if (imem_vld_p1 && (k == n_instr_q)) begin
            k     <= '0;
            state <= first_phase(1'b0, n_data_q != '0, run_cnt != '0, n_dump_q != '0);
          end
        end
        // ---- stage p1: accepted word becomes a one-cycle dmem write ----
        S_LOAD_D: begin
          if (hs) begin
            dmem_vld_p1  <= 1'b1;
            dmem_addr_p1 <= DMEM_BASE + dmem_off;
            dmem_data_p1 <= s_data;
            k            <= k + CNT_ONE;
          end else if (dmem_vld_p1 && (k == n_data_q)) begin
            k     <= '0;
            state <= first_phase(1'b0, 1'b0, run_cnt != '0, n_dump_q != '0);
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt - 32'd1;
          if (run_cnt == 32'd1) begin
            state <= first_phase(1'b0, 1'b0, 1'b0, n_dump_q != '0);
          end
        end
        S_DUMP_RD: state <= S_DUMP_CAP;
        // ---- stage p1: read data returns one cycle after the strobe ----
        S_DUMP_CAP: begin
          m_data_q <= rdata_ext_2;
          state    <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (m_ready) begin
            k     <= k + CNT_ONE;
            state <= ((k + CNT_ONE) == n_dump_q) ? S_DONE : S_DUMP_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign cpu_enable  = (state == S_RUN);
  assign wen_ext     = imem_vld_p1;
  assign addr_ext    = imem_addr_p1;
  assign wdata_ext   = imem_data_p1;
  assign ren_ext     = 1'b0;
  assign wen_ext_2   = dmem_vld_p1;
  assign ren_ext_2   = (state == S_DUMP_RD);
  assign addr_ext_2  = ren_ext_2 ? (DMEM_BASE + dmem_off) : dmem_addr_p1;
  assign wdata_ext_2 = dmem_data_p1;
  assign m_valid     = (state == S_DUMP_OUT);
  assign m_data      = m_data_q;

endmodule
